// File: rtl/neuron_mac_if.sv
// Bundle of signals between the neuron sequencer and its environment:
// start/bias control, shared weight/activation memory port, output stream.
// The slave modport is the sequencer side; master is the environment
// that owns the memories, the bias source and the downstream consumer.
interface neuron_mac_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] bias;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              w_en;
  logic [DATA_W-1:0] w_do;
  logic              x_en;
  logic [DATA_W-1:0] x_do;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  start, bias, w_do, x_do, out_ready,
    output busy, mem_addr, w_en, x_en, out_data, out_valid
  );

  modport master (
    output start, bias, w_do, x_do, out_ready,
    input  busy, mem_addr, w_en, x_en, out_data, out_valid
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Single-neuron MAC sequencer: walks taps 0..N_TAPS-1 over a shared address to
// the weight BRAM and activation memory (both read on negedge), accumulates
// W*X in Q8.8, adds the bias, saturates, and presents the result valid/ready.
// Optional macro NEURON_RELU_EN clamps negative results to zero.
module neuron_mac_seq #(
  parameter int N_TAPS = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic          clk,
  input  logic          rst,
  neuron_mac_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, OUTPUT} state_t;

  localparam int                       PROD_W  = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0]  SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic [ADDR_W-1:0]        LAST_M1 = ADDR_W'(N_TAPS - 2);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      en_q, en_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  bias_q, bias_d;
  logic signed [DATA_W-1:0]  out_q, out_d;
  logic                      vld_q, vld_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum, bias_sh, total, shr;
  logic signed [DATA_W-1:0]  sat, res;

  // Datapath: full-width product, running sum including the current tap,
  // bias aligned to the product's Q16.16 scale, then rescale and clamp.
  always_comb begin
    prod    = $signed(bus.w_do) * $signed(bus.x_do);
    acc_sum = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_sh = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_W;
    total   = acc_sum + bias_sh;
    shr     = total >>> FRAC_W;
    if (shr > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (shr < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                    sat = shr[DATA_W-1:0];
`ifdef NEURON_RELU_EN
    res = sat[DATA_W-1] ? '0 : sat;
`else
    res = sat;
`endif
  end

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    out_d   = out_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d   = '0;
        bias_d  = $signed(bus.bias);
        addr_d  = '0;
        en_d    = 1'b1;
        state_d = RUN;
      end
      // Each edge folds in the tap read at the previous address. The last
      // address stays enabled one more cycle so its negedge read happens.
      RUN: begin
        acc_d  = acc_sum;
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LAST_M1) state_d = FINISH;
      end
      FINISH: begin
        acc_d   = acc_sum;
        en_d    = 1'b0;
        out_d   = res;
        vld_d   = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: if (bus.out_ready) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      acc_q   <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.w_en      = en_q;
  assign bus.x_en      = en_q;
  assign bus.out_data  = out_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: table of {weights, activations, bias,
// expected result} plus hand sequences for backpressure and mid-run reset.
module tb_neuron_mac_seq;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_mac_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  neuron_mac_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [15:0] wmem [0:31];
  logic [15:0] xmem [0:31];

  // Memory models: registered read on the falling edge while enabled.
  always @(negedge clk) begin
    if (bus.w_en) bus.w_do <= wmem[bus.mem_addr];
    if (bus.x_en) bus.x_do <= xmem[bus.mem_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] w, input logic [15:0] x, input bit ramp);
    for (int i = 0; i < 32; i++) begin
      wmem[i] = w;
      xmem[i] = ramp ? 16'(i * 16) : x;
    end
  endtask

  // Starts a run, tracks the address walk and waits for OUT_VALID; leaves
  // the DUT holding its result in the output state.
  task automatic run_case(input string nm, input logic [15:0] b, input logic [15:0] exp);
    int  lat;
    int  seq_err;
    bit  got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bias  = 16'h5A5A;
    seq_err = 0;
    if (bus.mem_addr !== 5'd0 || bus.w_en !== 1'b1 || bus.x_en !== 1'b1) seq_err++;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge clk); #1;
      if (k <= 27) begin
        if (bus.mem_addr !== 5'(k) || bus.w_en !== 1'b1 || bus.x_en !== 1'b1) seq_err++;
      end else if (bus.w_en !== 1'b0 || bus.x_en !== 1'b0 || bus.mem_addr > 5'd27) begin
        seq_err++;
      end
      if (bus.out_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({nm, "_latency"}, lat, 28);
    chk({nm, "_addr_seq"}, seq_err, 0);
    chk({nm, "_data"}, {16'h0, bus.out_data}, {16'h0, exp});
    chk({nm, "_busy"}, {31'h0, bus.busy}, 1);
  endtask

  task automatic accept(input string nm);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_valid_clr"}, {31'h0, bus.out_valid}, 0);
    chk({nm, "_idle"}, {31'h0, bus.busy}, 0);
  endtask

  typedef struct {
    string       nm;
    logic [15:0] w;
    logic [15:0] x;
    bit          ramp;
    logic [15:0] bias;
    logic [15:0] exp_lin;
    logic [15:0] exp_relu;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"unity",   16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h1C00, 16'h1C00};
    vecs[1] = '{"neg",     16'hFF00, 16'h0100, 1'b0, 16'h0200, 16'hE600, 16'h0000};
    vecs[2] = '{"sat_pos", 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{"sat_neg", 16'h8000, 16'h7FFF, 1'b0, 16'h0000, 16'h8000, 16'h0000};
    vecs[4] = '{"ramp",    16'h0100, 16'h0000, 1'b1, 16'h0000, 16'h17A0, 16'h17A0};
    vecs[5] = '{"floor",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[6] = '{"bias_only",16'h0000,16'h1234, 1'b0, 16'hFF80, 16'hFF80, 16'h0000};

    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;
    bus.w_do      = '0;
    bus.x_do      = '0;
    load(16'h0, 16'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'h0, bus.busy}, 0);
    chk("rst_wen",   {31'h0, bus.w_en}, 0);
    chk("rst_xen",   {31'h0, bus.x_en}, 0);
    chk("rst_valid", {31'h0, bus.out_valid}, 0);
    chk("rst_addr",  {27'h0, bus.mem_addr}, 0);
    chk("rst_data",  {16'h0, bus.out_data}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load(vecs[i].w, vecs[i].x, vecs[i].ramp);
      run_case(vecs[i].nm, vecs[i].bias, RELU ? vecs[i].exp_relu : vecs[i].exp_lin);
      accept(vecs[i].nm);
    end

    // Backpressure: result held for 10 cycles, START ignored meanwhile.
    begin
      int unstable;
      load(16'h0100, 16'h0100, 1'b0);
      run_case("bp", 16'h0000, 16'h1C00);
      unstable = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        bus.start = (c == 3 || c == 4);
        bus.bias  = 16'h7F00;
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1C00 ||
            bus.busy !== 1'b1 || bus.w_en !== 1'b0) unstable++;
      end
      bus.start = 1'b0;
      chk("bp_hold", unstable, 0);
      accept("bp");
      @(posedge clk); #1;
      chk("bp_no_queue", {31'h0, bus.busy}, 0);
    end

    // Mid-run reset discards the accumulation in one edge.
    load(16'h0100, 16'h0100, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy",  {31'h0, bus.busy}, 0);
    chk("mrst_en",    {30'h0, bus.w_en, bus.x_en}, 0);
    chk("mrst_addr",  {27'h0, bus.mem_addr}, 0);
    chk("mrst_valid", {31'h0, bus.out_valid}, 0);
    chk("mrst_data",  {16'h0, bus.out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_case("after_rst", 16'h0000, 16'h1C00);
    accept("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
